// File: rtl/riscv_mem_ctrl.sv
// Byte-serial load/store/fetch sequencer between the RV32 core and a byte-wide BRAM.
// Arbitrates fetch and data ports, splits accesses into little-endian byte cycles and extends loads.
//
//  state  | meaning
//  -------+---------------------------------------------------------------
//  S_IDLE | waiting for a request; ready is combinational from valid
//  S_XFER | one BRAM byte per cycle, k = 0 .. n-1
//  S_RESP | one-cycle response pulse to the granted requester
module riscv_mem_ctrl #(
    parameter int ADDR_LENGTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_req_valid,
    output logic                   i_req_ready,
    input  logic [ADDR_LENGTH-1:0] i_addr,
    output logic                   i_rsp_valid,
    output logic [31:0]            i_rdata,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic                   d_we,
    input  logic [2:0]             d_funct3,
    input  logic [ADDR_LENGTH-1:0] d_addr,
    input  logic [31:0]            d_wdata,
    output logic                   d_rsp_valid,
    output logic [31:0]            d_rdata,
    output logic                   d_err,
    output logic                   bram_write_en,
    output logic [ADDR_LENGTH-1:0] bram_waddr,
    output logic [7:0]             bram_wdata,
    output logic [ADDR_LENGTH-1:0] bram_raddr,
    input  logic [7:0]             bram_dout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_LENGTH-1:0] base_q;
    logic [ADDR_LENGTH-1:0] addr_hold_q;
    logic [ADDR_LENGTH-1:0] cur_addr;
    logic [1:0]             k_q;
    logic [1:0]             k_last_q;
    logic [1:0]             size_q;
    logic                   we_q;
    logic                   sgn_q;
    logic                   is_d_q;
    logic                   err_q;
    logic                   last_d_q;
    logic [31:0]            wdata_q;
    logic [31:0]            result_q;
    logic [31:0]            ext_data;
    logic                   d_grant;
    logic                   i_grant;
    logic                   d_illegal;
    logic [1:0]             d_k_last;
    logic                   rsp_d;
    logic                   rsp_i;

    // Data wins unless it also won last time and a fetch is waiting.
    assign d_grant = (state_q == S_IDLE) && d_req_valid && !(last_d_q && i_req_valid);
    assign i_grant = (state_q == S_IDLE) && i_req_valid && !d_grant;

    assign d_illegal = (d_funct3[1:0] == 2'b11)
                    || (d_funct3[2] && (d_we || d_funct3[1]))
                    || ((d_funct3[1:0] == 2'b01) && d_addr[0])
                    || ((d_funct3[1:0] == 2'b10) && (d_addr[1:0] != 2'b00));

    always_comb begin
        d_k_last = 2'd3;
        case (d_funct3[1:0])
            2'b00:   d_k_last = 2'd0;
            2'b01:   d_k_last = 2'd1;
            default: d_k_last = 2'd3;
        endcase
    end

    assign cur_addr = base_q + {{(ADDR_LENGTH-2){1'b0}}, k_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (d_grant) begin
                    state_d = d_illegal ? S_RESP : S_XFER;
                end else if (i_grant) begin
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (k_q == k_last_q) begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_hold_q <= '0;
            k_q         <= 2'd0;
            k_last_q    <= 2'd0;
            size_q      <= 2'd0;
            we_q        <= 1'b0;
            sgn_q       <= 1'b0;
            is_d_q      <= 1'b0;
            err_q       <= 1'b0;
            last_d_q    <= 1'b0;
            wdata_q     <= '0;
            result_q    <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (d_grant) begin
                        base_q   <= d_addr;
                        k_q      <= 2'd0;
                        k_last_q <= d_k_last;
                        size_q   <= d_funct3[1:0];
                        we_q     <= d_we;
                        sgn_q    <= !d_funct3[2];
                        is_d_q   <= 1'b1;
                        err_q    <= d_illegal;
                        last_d_q <= 1'b1;
                        wdata_q  <= d_wdata;
                        result_q <= '0;
                    end else if (i_grant) begin
                        base_q   <= i_addr & ~ADDR_LENGTH'(3);
                        k_q      <= 2'd0;
                        k_last_q <= 2'd3;
                        size_q   <= 2'b10;
                        we_q     <= 1'b0;
                        sgn_q    <= 1'b0;
                        is_d_q   <= 1'b0;
                        err_q    <= 1'b0;
                        last_d_q <= 1'b0;
                        result_q <= '0;
                    end
                end
                S_XFER: begin
                    k_q         <= k_q + 2'd1;
                    addr_hold_q <= cur_addr;
                    if (!we_q) begin
                        result_q[{k_q, 3'b000} +: 8] <= bram_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ext_data = result_q;
        case (size_q)
            2'b00:   ext_data = {{24{sgn_q & result_q[7]}}, result_q[7:0]};
            2'b01:   ext_data = {{16{sgn_q & result_q[15]}}, result_q[15:0]};
            default: ext_data = result_q;
        endcase
    end

    // Outputs are gated by rst_n so a reset mid-transfer stops the next BRAM write.
    assign rsp_d = rst_n && (state_q == S_RESP) && is_d_q;
    assign rsp_i = rst_n && (state_q == S_RESP) && !is_d_q;

    assign d_req_ready   = rst_n && d_grant;
    assign i_req_ready   = rst_n && i_grant;
    assign d_rsp_valid   = rsp_d;
    assign d_err         = rsp_d && err_q;
    assign d_rdata       = (rsp_d && !err_q && !we_q) ? ext_data : 32'd0;
    assign i_rsp_valid   = rsp_i;
    assign i_rdata       = rsp_i ? result_q : 32'd0;
    assign bram_write_en = rst_n && (state_q == S_XFER) && we_q;
    assign bram_wdata    = bram_write_en ? wdata_q[{k_q, 3'b000} +: 8] : 8'd0;
    assign bram_raddr    = !rst_n ? '0 : ((state_q == S_XFER) ? cur_addr : addr_hold_q);
    assign bram_waddr    = bram_raddr;

endmodule
